// File: rtl/vm_pkg.sv
// Shared definitions for the vending machine change path: coin values,
// product prices, legal change amounts and dispenser state encoding.
package vm_pkg;
  localparam logic [4:0] COIN5  = 5'd5;
  localparam logic [4:0] COIN10 = 5'd10;

  localparam logic [4:0] PRICE_A = 5'd15;
  localparam logic [4:0] PRICE_B = 5'd20;
  localparam logic [4:0] PRICE_C = 5'd25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAN,
    ST_FIRE10,
    ST_WAIT10,
    ST_FIRE5,
    ST_WAIT5,
    ST_DONE
  } disp_state_t;

  function automatic logic legal_change(input logic [4:0] amt);
    return amt inside {5'd0, 5'd5, 5'd10, 5'd15, 5'd20};
  endfunction
endpackage

// File: rtl/vm_hopper_if.sv
// One coin hopper handshake: fire pulse, ack wait and jam timeout.
module vm_hopper_if #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic arm,
  input  logic waiting,
  input  logic ack,
  output logic fire,
  output logic acked,
  output logic timeout
);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               cnt <= '0;
    else if (arm)               cnt <= '0;
    else if (waiting && !ack)   cnt <= cnt + CNT_W'(1);
  end

  assign fire    = arm;
  assign acked   = waiting && ack;
  // the last waited cycle without ack declares the hopper jammed
  assign timeout = waiting && !ack && (cnt == CNT_W'(ACK_TIMEOUT - 1));
endmodule

// File: rtl/vm_change_dispenser.sv
// Change dispenser: greedy 10-then-5 payout over two hoppers with
// saturating inventories, jam detection and shortfall reporting.
module vm_change_dispenser
  import vm_pkg::*;
#(
  parameter int INV_W       = 8,
  parameter int INV10_INIT  = 20,
  parameter int INV5_INIT   = 20,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic [4:0]       req_amount,
  output logic             req_ready,
  output logic             hop10_fire,
  input  logic             hop10_ack,
  output logic             hop5_fire,
  input  logic             hop5_ack,
  input  logic             refill_en,
  input  logic [INV_W-1:0] refill10,
  input  logic [INV_W-1:0] refill5,
  output logic             busy,
  output logic             done,
  output logic [4:0]       paid_out,
  output logic             short,
  output logic             fault,
  output logic [INV_W-1:0] inv10,
  output logic [INV_W-1:0] inv5
);
  disp_state_t state, state_nx;
  logic [4:0]  remaining, paid;
  logic        illegal;
  logic        got10, to10, got5, to5;

  vm_hopper_if #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_hop10 (
    .clk(clk), .reset_n(reset_n),
    .arm(state == ST_FIRE10), .waiting(state == ST_WAIT10), .ack(hop10_ack),
    .fire(hop10_fire), .acked(got10), .timeout(to10)
  );

  vm_hopper_if #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_hop5 (
    .clk(clk), .reset_n(reset_n),
    .arm(state == ST_FIRE5), .waiting(state == ST_WAIT5), .ack(hop5_ack),
    .fire(hop5_fire), .acked(got5), .timeout(to5)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (req_valid) state_nx = ST_PLAN;
      ST_PLAN: begin
        if (remaining >= COIN10 && inv10 != '0)     state_nx = ST_FIRE10;
        else if (remaining >= COIN5 && inv5 != '0) state_nx = ST_FIRE5;
        else                                        state_nx = ST_DONE;
      end
      ST_FIRE10: state_nx = ST_WAIT10;
      ST_WAIT10: if (got10 || to10) state_nx = ST_PLAN;
      ST_FIRE5:  state_nx = ST_WAIT5;
      ST_WAIT5:  if (got5 || to5) state_nx = ST_PLAN;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // illegal amounts still pass through PLAN with nothing to pay, so every
  // request has the same minimum two-cycle turnaround
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining <= '0;
      paid      <= '0;
      illegal   <= 1'b0;
      paid_out  <= '0;
      short     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (req_valid) begin
          remaining <= legal_change(req_amount) ? req_amount : 5'd0;
          illegal   <= !legal_change(req_amount);
          paid      <= '0;
        end
        ST_PLAN: if (state_nx == ST_DONE) begin
          paid_out <= paid;
          short    <= illegal || (remaining != '0);
        end
        ST_WAIT10: if (got10) begin
          remaining <= remaining - COIN10;
          paid      <= paid + COIN10;
        end
        ST_WAIT5: if (got5) begin
          remaining <= remaining - COIN5;
          paid      <= paid + COIN5;
        end
        default: ;
      endcase
    end
  end

  function automatic logic [INV_W-1:0] inv_next(
    input logic [INV_W-1:0] cur,
    input logic             dec,
    input logic             jam,
    input logic             add_en,
    input logic [INV_W-1:0] add
  );
    logic [INV_W-1:0] base;
    logic [INV_W:0]   sum;
    base = jam ? '0 : (dec && cur != '0) ? cur - INV_W'(1) : cur;
    sum  = {1'b0, base} + {1'b0, (add_en ? add : {INV_W{1'b0}})};
    return sum[INV_W] ? {INV_W{1'b1}} : sum[INV_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inv10 <= INV_W'(INV10_INIT);
      inv5  <= INV_W'(INV5_INIT);
      fault <= 1'b0;
    end else begin
      inv10 <= inv_next(inv10, got10, to10, refill_en, refill10);
      inv5  <= inv_next(inv5, got5, to5, refill_en, refill5);
      if (to10 || to5)    fault <= 1'b1;
      else if (refill_en) fault <= 1'b0;
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
endmodule
